// File: rtl/dst_axis_packer.sv
// dst_axis_packer
// Packs a 24-bit RGB888 pixel stream into a byte-packed 32-bit AXI-Stream,
// checking line length and counting lines to mark frame boundaries.
//
// Ports:
//   clk, rst            single clock, synchronous active-high reset
//   s_axis_*            pixel input (tdata[7:0] is the first byte), user = frame start
//   m_axis_*            packed word output (lane 0 = oldest byte), user = first word of frame
//   line_err            sticky: dropped pixel, mid-frame restart, or line length mismatch
//   frame_done          one-cycle pulse when the last word of a frame is taken
//   err_cnt             (only with DST_PACKER_ERR_CNT_EN) saturating error event count
//
// Optional feature macro: DST_PACKER_ERR_CNT_EN
module dst_axis_packer #(
  parameter int DST_IMG_WIDTH  = 3840,
  parameter int DST_IMG_HEIGHT = 2160
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic [23:0] s_axis_tdata,
  input  logic        s_axis_tlast,
  input  logic        s_axis_user,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic [31:0] m_axis_tdata,
  output logic [3:0]  m_axis_tkeep,
  output logic        m_axis_tlast,
  output logic        m_axis_user,
  output logic        line_err,
  output logic        frame_done
`ifdef DST_PACKER_ERR_CNT_EN
  ,
  output logic [15:0] err_cnt
`endif
);

  localparam int PW = (DST_IMG_WIDTH  > 1) ? $clog2(DST_IMG_WIDTH)  : 1;
  localparam int LW = (DST_IMG_HEIGHT > 1) ? $clog2(DST_IMG_HEIGHT) : 1;
  localparam logic [PW-1:0] PIX_LAST  = PW'(DST_IMG_WIDTH - 1);
  localparam logic [LW-1:0] LINE_LAST = LW'(DST_IMG_HEIGHT - 1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
    logic        user;
    logic        fend;   // last word of the frame
  } word_t;

  state_t        state, state_d;
  word_t         out_q, word_d;
  logic          out_vld;
  logic [1:0]    res_cnt, res_d, res_b;
  logic [23:0]   res_buf, buf_d;
  logic [PW-1:0] pix_cnt, pix_d, pix_b;
  logic [LW-1:0] line_cnt, line_d, line_b;
  logic          user_pend, upend_d, upend_b;
  logic          flush_fend, ffend_d;
  logic          line_err_q;
  logic          out_free, acc, fstart, frame_last, ld, err_evt;
  logic [47:0]   cat;
  logic [2:0]    total;

  assign out_free      = !out_vld || m_axis_tready;
  assign s_axis_tready = out_free && (state != FLUSH);
  assign acc           = s_axis_tvalid && s_axis_tready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    res_d   = res_cnt;
    buf_d   = res_buf;
    pix_d   = pix_cnt;
    line_d  = line_cnt;
    upend_d = user_pend;
    ffend_d = flush_fend;
    ld      = 1'b0;
    word_d  = '0;
    err_evt = 1'b0;
    // A frame-start pixel restarts packing and counting from scratch.
    fstart     = acc && s_axis_user;
    res_b      = fstart ? 2'd0 : res_cnt;
    pix_b      = fstart ? '0 : pix_cnt;
    line_b     = fstart ? '0 : line_cnt;
    upend_b    = fstart | user_pend;
    frame_last = (line_b == LINE_LAST);
    // Residual bytes sit low, the new pixel is appended above them.
    cat   = {24'd0, (res_b == 2'd0) ? 24'd0 : res_buf} |
            ({24'd0, s_axis_tdata} << {res_b, 3'b000});
    total = {1'b0, res_b} + 3'd3;

    if (state == FLUSH) begin
      if (out_free) begin
        ld          = 1'b1;
        word_d.data = {8'd0, res_buf};
        word_d.keep = (4'd1 << res_cnt) - 4'd1;
        word_d.last = 1'b1;
        word_d.user = user_pend;
        word_d.fend = flush_fend;
        upend_d     = 1'b0;
        res_d       = 2'd0;
        buf_d       = '0;
        state_d     = flush_fend ? IDLE : RUN;
      end
    end else if (acc) begin
      if (state == IDLE && !s_axis_user) begin
        err_evt = 1'b1;                        // no frame open: drop
      end else begin
        if (state == RUN && s_axis_user) err_evt = 1'b1;
        if (total[2]) begin
          ld          = 1'b1;
          word_d.data = cat[31:0];
          word_d.keep = 4'hF;
          word_d.user = upend_b;
          upend_d     = 1'b0;
          res_d       = total[1:0];            // total - 4
          buf_d       = {8'd0, cat[47:32]};
        end else begin
          res_d   = 2'd3;
          buf_d   = cat[23:0];
          upend_d = upend_b;
        end
        if (s_axis_tlast) begin
          if (pix_b != PIX_LAST) err_evt = 1'b1;
          pix_d  = '0;
          line_d = frame_last ? '0 : line_b + 1'b1;
          if (res_d != 2'd0) begin
            state_d = FLUSH;
            ffend_d = frame_last;
          end else begin
            word_d.last = 1'b1;
            word_d.fend = frame_last;
            state_d     = frame_last ? IDLE : RUN;
          end
        end else begin
          if (pix_b == PIX_LAST) err_evt = 1'b1;
          pix_d   = pix_b + 1'b1;
          state_d = RUN;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q      <= '0;
      out_vld    <= 1'b0;
      res_cnt    <= 2'd0;
      res_buf    <= '0;
      pix_cnt    <= '0;
      line_cnt   <= '0;
      user_pend  <= 1'b0;
      flush_fend <= 1'b0;
      line_err_q <= 1'b0;
    end else begin
      if (ld) begin
        out_q   <= word_d;
        out_vld <= 1'b1;
      end else if (m_axis_tready) begin
        out_vld <= 1'b0;
      end
      res_cnt    <= res_d;
      res_buf    <= buf_d;
      pix_cnt    <= pix_d;
      line_cnt   <= line_d;
      user_pend  <= upend_d;
      flush_fend <= ffend_d;
      line_err_q <= line_err_q | err_evt;
    end
  end

`ifdef DST_PACKER_ERR_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)                                err_cnt <= 16'd0;
    else if (err_evt && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
  end
`endif

  assign m_axis_tvalid = out_vld;
  assign m_axis_tdata  = out_q.data;
  assign m_axis_tkeep  = out_q.keep;
  assign m_axis_tlast  = out_q.last;
  assign m_axis_user   = out_q.user;
  assign line_err      = line_err_q;
  assign frame_done    = out_vld && m_axis_tready && out_q.fend;

endmodule

// File: tb/tb_dst_axis_packer.sv
// Directed bench for dst_axis_packer. Instance a: WIDTH=4 HEIGHT=2,
// instance b: WIDTH=5 HEIGHT=1. Inputs are shared; sel picks which
// instance receives s_axis_tvalid. Words are logged as {user,last,keep,data}.
module tb_dst_axis_packer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tv = 1'b0, sel = 1'b0, mready = 1'b0;
  logic [23:0] s_data = '0;
  logic s_last = 1'b0, s_user = 1'b0;

  logic a_tready, a_mvalid, a_last, a_user, a_lerr, a_fdone;
  logic [31:0] a_data;
  logic [3:0] a_keep;
  logic b_tready, b_mvalid, b_last, b_user, b_lerr, b_fdone;
  logic [31:0] b_data;
  logic [3:0] b_keep;
`ifdef DST_PACKER_ERR_CNT_EN
  logic [15:0] a_ecnt, b_ecnt;
`endif

  logic [37:0] qa[$], qb[$];
  int fa = 0, fb = 0;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  dst_axis_packer #(.DST_IMG_WIDTH(4), .DST_IMG_HEIGHT(2)) u_a (
    .clk(clk), .rst(rst),
    .s_axis_tvalid(tv && !sel), .s_axis_tready(a_tready), .s_axis_tdata(s_data),
    .s_axis_tlast(s_last), .s_axis_user(s_user),
    .m_axis_tvalid(a_mvalid), .m_axis_tready(mready), .m_axis_tdata(a_data),
    .m_axis_tkeep(a_keep), .m_axis_tlast(a_last), .m_axis_user(a_user),
    .line_err(a_lerr), .frame_done(a_fdone)
`ifdef DST_PACKER_ERR_CNT_EN
    , .err_cnt(a_ecnt)
`endif
  );

  dst_axis_packer #(.DST_IMG_WIDTH(5), .DST_IMG_HEIGHT(1)) u_b (
    .clk(clk), .rst(rst),
    .s_axis_tvalid(tv && sel), .s_axis_tready(b_tready), .s_axis_tdata(s_data),
    .s_axis_tlast(s_last), .s_axis_user(s_user),
    .m_axis_tvalid(b_mvalid), .m_axis_tready(mready), .m_axis_tdata(b_data),
    .m_axis_tkeep(b_keep), .m_axis_tlast(b_last), .m_axis_user(b_user),
    .line_err(b_lerr), .frame_done(b_fdone)
`ifdef DST_PACKER_ERR_CNT_EN
    , .err_cnt(b_ecnt)
`endif
  );

  always @(negedge clk) begin
    if (!rst) begin
      if (a_mvalid && mready) qa.push_back({a_user, a_last, a_keep, a_data});
      if (b_mvalid && mready) qb.push_back({b_user, b_last, b_keep, b_data});
      if (a_fdone) fa++;
      if (b_fdone) fb++;
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1; tv = 1'b0; mready = 1'b1; s_user = 1'b0; s_last = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    qa.delete(); qb.delete(); fa = 0; fb = 0;
  endtask

  task automatic send_pix(input logic [23:0] d, input logic l, input logic u);
    int n = 0;
    s_data = d; s_last = l; s_user = u; tv = 1'b1;
    @(negedge clk);
    while (!(sel ? b_tready : a_tready) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++; failures++;
      $display("FAIL send_timeout: tready low for %0d cycles, required high", n);
    end
    @(posedge clk);
    #1 tv = 1'b0; s_last = 1'b0; s_user = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; tv = 1'b0; mready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (a_mvalid !== 1'b0)   begin failures++; $display("FAIL rst_tvalid: got %b want 0", a_mvalid); end
    checks++; if (a_data !== 32'h0)    begin failures++; $display("FAIL rst_tdata: got %h want 0", a_data); end
    checks++; if (a_keep !== 4'h0)     begin failures++; $display("FAIL rst_tkeep: got %h want 0", a_keep); end
    checks++; if ({a_last, a_user} !== 2'b00) begin failures++; $display("FAIL rst_last_user: got %b want 00", {a_last, a_user}); end
    checks++; if ({a_lerr, a_fdone} !== 2'b00) begin failures++; $display("FAIL rst_err_done: got %b want 00", {a_lerr, a_fdone}); end
`ifdef DST_PACKER_ERR_CNT_EN
    checks++; if (a_ecnt !== 16'd0)    begin failures++; $display("FAIL rst_err_cnt: got %0d want 0", a_ecnt); end
`endif
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if ({a_tready, b_tready} !== 2'b11) begin failures++; $display("FAIL rst_tready: got %b want 11", {a_tready, b_tready}); end
  endtask

  // Two-line frame of 4 pixels per line, then a stray pixel while idle.
  task automatic test_basic();
    logic [37:0] exp [6];
    do_reset(); sel = 1'b0;
    send_pix(24'h030201, 1'b0, 1'b1);
    send_pix(24'h060504, 1'b0, 1'b0);
    send_pix(24'h090807, 1'b0, 1'b0);
    send_pix(24'h0C0B0A, 1'b1, 1'b0);
    wait_cycles(3);
    checks++; if (fa !== 0) begin failures++; $display("FAIL basic_no_early_done: got %0d want 0", fa); end
    send_pix(24'h0F0E0D, 1'b0, 1'b0);
    send_pix(24'h121110, 1'b0, 1'b0);
    send_pix(24'h151413, 1'b0, 1'b0);
    send_pix(24'h181716, 1'b1, 1'b0);
    wait_cycles(3);
    exp[0] = {1'b1, 1'b0, 4'hF, 32'h04030201};
    exp[1] = {1'b0, 1'b0, 4'hF, 32'h08070605};
    exp[2] = {1'b0, 1'b1, 4'hF, 32'h0C0B0A09};
    exp[3] = {1'b0, 1'b0, 4'hF, 32'h100F0E0D};
    exp[4] = {1'b0, 1'b0, 4'hF, 32'h14131211};
    exp[5] = {1'b0, 1'b1, 4'hF, 32'h18171615};
    checks++; if (qa.size() !== 6) begin failures++; $display("FAIL basic_count: got %0d want 6", qa.size()); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (qa.size() <= i || qa[i] !== exp[i]) begin
        failures++;
        $display("FAIL basic_word%0d: got %h want %h", i, (qa.size() > i) ? qa[i] : 38'hx, exp[i]);
      end
    end
    checks++; if (a_lerr !== 1'b0) begin failures++; $display("FAIL basic_line_err: got %b want 0", a_lerr); end
    checks++; if (fa !== 1) begin failures++; $display("FAIL basic_frame_done: got %0d want 1", fa); end
    // Frame closed: a pixel without user is dropped and flagged.
    send_pix(24'h111111, 1'b0, 1'b0);
    wait_cycles(3);
    checks++; if (qa.size() !== 6) begin failures++; $display("FAIL idle_drop_count: got %0d want 6", qa.size()); end
    checks++; if (a_lerr !== 1'b1) begin failures++; $display("FAIL idle_drop_err: got %b want 1", a_lerr); end
  endtask

  // Width 5: 15 bytes -> three full words and a 3-byte flush.
  task automatic test_flush();
    logic [37:0] exp [4];
    do_reset(); sel = 1'b1;
    send_pix(24'h030201, 1'b0, 1'b1);
    send_pix(24'h060504, 1'b0, 1'b0);
    send_pix(24'h090807, 1'b0, 1'b0);
    send_pix(24'h0C0B0A, 1'b0, 1'b0);
    send_pix(24'h0F0E0D, 1'b1, 1'b0);
    wait_cycles(4);
    exp[0] = {1'b1, 1'b0, 4'hF, 32'h04030201};
    exp[1] = {1'b0, 1'b0, 4'hF, 32'h08070605};
    exp[2] = {1'b0, 1'b0, 4'hF, 32'h0C0B0A09};
    exp[3] = {1'b0, 1'b1, 4'h7, 32'h000F0E0D};
    checks++; if (qb.size() !== 4) begin failures++; $display("FAIL flush_count: got %0d want 4", qb.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (qb.size() <= i || qb[i] !== exp[i]) begin
        failures++;
        $display("FAIL flush_word%0d: got %h want %h", i, (qb.size() > i) ? qb[i] : 38'hx, exp[i]);
      end
    end
    checks++; if (b_lerr !== 1'b0) begin failures++; $display("FAIL flush_line_err: got %b want 0", b_lerr); end
    checks++; if (fb !== 1) begin failures++; $display("FAIL flush_frame_done: got %0d want 1", fb); end
  endtask

  // Downstream stall with one word pending.
  task automatic test_stall();
    logic [37:0] exp [3];
    do_reset(); sel = 1'b0; mready = 1'b0;
    send_pix(24'h030201, 1'b0, 1'b1);
    send_pix(24'h060504, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({a_tready, a_mvalid, a_data} !== {1'b0, 1'b1, 32'h04030201}) begin
        failures++;
        $display("FAIL stall_cyc%0d: got rdy=%b vld=%b data=%h want rdy=0 vld=1 data=04030201",
                 i, a_tready, a_mvalid, a_data);
      end
      @(posedge clk); #1;
    end
    mready = 1'b1;
    send_pix(24'h090807, 1'b0, 1'b0);
    send_pix(24'h0C0B0A, 1'b1, 1'b0);
    wait_cycles(3);
    exp[0] = {1'b1, 1'b0, 4'hF, 32'h04030201};
    exp[1] = {1'b0, 1'b0, 4'hF, 32'h08070605};
    exp[2] = {1'b0, 1'b1, 4'hF, 32'h0C0B0A09};
    checks++; if (qa.size() !== 3) begin failures++; $display("FAIL stall_count: got %0d want 3", qa.size()); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (qa.size() <= i || qa[i] !== exp[i]) begin
        failures++;
        $display("FAIL stall_word%0d: got %h want %h", i, (qa.size() > i) ? qa[i] : 38'hx, exp[i]);
      end
    end
  endtask

  // Early tlast after 3 pixels at width 4.
  task automatic test_short_line();
    logic [37:0] exp [3];
    do_reset(); sel = 1'b0;
    send_pix(24'h030201, 1'b0, 1'b1);
    send_pix(24'h060504, 1'b0, 1'b0);
    send_pix(24'h090807, 1'b1, 1'b0);
    wait_cycles(4);
    exp[0] = {1'b1, 1'b0, 4'hF, 32'h04030201};
    exp[1] = {1'b0, 1'b0, 4'hF, 32'h08070605};
    exp[2] = {1'b0, 1'b1, 4'h1, 32'h00000009};
    checks++; if (qa.size() !== 3) begin failures++; $display("FAIL short_count: got %0d want 3", qa.size()); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (qa.size() <= i || qa[i] !== exp[i]) begin
        failures++;
        $display("FAIL short_word%0d: got %h want %h", i, (qa.size() > i) ? qa[i] : 38'hx, exp[i]);
      end
    end
    checks++; if (a_lerr !== 1'b1) begin failures++; $display("FAIL short_line_err: got %b want 1", a_lerr); end
`ifdef DST_PACKER_ERR_CNT_EN
    checks++; if (a_ecnt !== 16'd1) begin failures++; $display("FAIL short_err_cnt: got %0d want 1", a_ecnt); end
`endif
  endtask

  // Reset with a word pending, then a clean frame.
  task automatic test_reset_mid();
    logic [37:0] exp [6];
    do_reset(); sel = 1'b0; mready = 1'b0;
    send_pix(24'hAAAAAA, 1'b0, 1'b1);
    send_pix(24'hBBBBBB, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; mready = 1'b1;
    send_pix(24'h030201, 1'b0, 1'b1);
    send_pix(24'h060504, 1'b0, 1'b0);
    send_pix(24'h090807, 1'b0, 1'b0);
    send_pix(24'h0C0B0A, 1'b1, 1'b0);
    send_pix(24'h0F0E0D, 1'b0, 1'b0);
    send_pix(24'h121110, 1'b0, 1'b0);
    send_pix(24'h151413, 1'b0, 1'b0);
    send_pix(24'h181716, 1'b1, 1'b0);
    wait_cycles(5);
    exp[0] = {1'b1, 1'b0, 4'hF, 32'h04030201};
    exp[1] = {1'b0, 1'b0, 4'hF, 32'h08070605};
    exp[2] = {1'b0, 1'b1, 4'hF, 32'h0C0B0A09};
    exp[3] = {1'b0, 1'b0, 4'hF, 32'h100F0E0D};
    exp[4] = {1'b0, 1'b0, 4'hF, 32'h14131211};
    exp[5] = {1'b0, 1'b1, 4'hF, 32'h18171615};
    checks++; if (qa.size() !== 6) begin failures++; $display("FAIL rstmid_count: got %0d want 6", qa.size()); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (qa.size() <= i || qa[i] !== exp[i]) begin
        failures++;
        $display("FAIL rstmid_word%0d: got %h want %h", i, (qa.size() > i) ? qa[i] : 38'hx, exp[i]);
      end
    end
    checks++; if (fa !== 1) begin failures++; $display("FAIL rstmid_frame_done: got %0d want 1", fa); end
    checks++; if (a_lerr !== 1'b0) begin failures++; $display("FAIL rstmid_line_err: got %b want 0", a_lerr); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_flush();
    test_stall();
    test_short_line();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
